pipeline_regfile: RTL and testbench

- 32 x 32-bit general-purpose register file. It is the write-side responder for the pipeline writeback stage and the read-side provider for decode.
- Accepts one write per cycle on the we/windex/win port.
- Serves two combinational read ports, with same-cycle write-to-read bypass.
- Keeps a per-register pending-load scoreboard so decode can stall on load-use hazards.

---
 rtl/pipeline_regfile_pkg.sv | 7 +
 rtl/pipeline_regfile_scoreboard.sv | 44 ++++
 rtl/pipeline_regfile.sv | 57 +++++
 tb/tb_pipeline_regfile.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_regfile_pkg.sv
// Shared pipeline constants for the register file and its load scoreboard.
package pipeline_regfile_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/pipeline_regfile_scoreboard.sv
// Per-register pending-load scoreboard with load-use busy lookups for both read ports.
module pipeline_regfile_scoreboard
  import pipeline_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] windex,
  input  logic                 pend_set,
  input  logic [REG_IDX_W-1:0] pend_index,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] raddr_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [NREGS-1:0]     pending
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] set_vec, clr_vec;
  logic             wr_hit_a, wr_hit_b;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (pend_set && pend_index != REG_ZERO) set_vec = NREGS'(1) << pend_index;
    if (we && windex != REG_ZERO)           clr_vec = NREGS'(1) << windex;
    // A set overrides a same-cycle write: the write is from an older instruction.
    if (flush) pend_d = '0;
    else       pend_d = set_vec | (pend_q & ~clr_vec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign wr_hit_a = we && (windex == raddr_a);
  assign wr_hit_b = we && (windex == raddr_b);
  assign busy_a   = pend_q[raddr_a] && !wr_hit_a;
  assign busy_b   = pend_q[raddr_b] && !wr_hit_b;
  assign pending  = pend_q;

endmodule

// File: rtl/pipeline_regfile.sv
// 32x32 register file: one write port, two combinational read ports with write bypass.
module pipeline_regfile
  import pipeline_regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] windex,
  input  logic [XLEN-1:0]      win,
  input  logic [REG_IDX_W-1:0] raddr_a,
  output logic [XLEN-1:0]      rdata_a,
  input  logic [REG_IDX_W-1:0] raddr_b,
  output logic [XLEN-1:0]      rdata_b,
  input  logic                 pend_set,
  input  logic [REG_IDX_W-1:0] pend_index,
  input  logic                 flush,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [NREGS-1:0]     pending
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we && windex != REG_ZERO) begin
      regs_q[windex] <= win;
    end
  end

  // Bypass is gated by rst_n too, so a write presented during reset never leaks out.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    if (rst_n && raddr_a != REG_ZERO)
      rdata_a = (we && windex == raddr_a) ? win : regs_q[raddr_a];
    if (rst_n && raddr_b != REG_ZERO)
      rdata_b = (we && windex == raddr_b) ? win : regs_q[raddr_b];
  end

  pipeline_regfile_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .windex     (windex),
    .pend_set   (pend_set),
    .pend_index (pend_index),
    .flush      (flush),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .pending    (pending)
  );

endmodule

// File: tb/tb_pipeline_regfile.sv
// Scoreboard bench for pipeline_regfile: directed scenarios then randomized traffic vs a behavioural model.
module tb_pipeline_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  windex = '0;
  logic [31:0] win = '0;
  logic [4:0]  raddr_a = '0;
  logic [4:0]  raddr_b = '0;
  logic        pend_set = 1'b0;
  logic [4:0]  pend_index = '0;
  logic        flush = 1'b0;
  logic [31:0] rdata_a, rdata_b, pending;
  logic        busy_a, busy_b;

  pipeline_regfile dut (
    .clk(clk), .rst_n(rst_n), .we(we), .windex(windex), .win(win),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .pend_set(pend_set), .pend_index(pend_index), .flush(flush),
    .busy_a(busy_a), .busy_b(busy_b), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        busy_a;
    logic        busy_b;
    logic [31:0] pending;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: architectural values and the set of outstanding load destinations.
  logic [31:0] model_regs [32];
  bit          model_pend [32];

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      model_pend[i] = 1'b0;
    end
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endfunction

  // Drive one cycle of inputs, record what the outputs must show, then advance the model.
  task automatic drive(input bit w, input int wi, input logic [31:0] wd,
                       input int ra, input int rb,
                       input bit ps, input int pi, input bit fl);
    exp_t e;
    @(negedge clk);
    we = w; windex = wi[4:0]; win = wd;
    raddr_a = ra[4:0]; raddr_b = rb[4:0];
    pend_set = ps; pend_index = pi[4:0]; flush = fl;
    e.pending = '0;
    for (int i = 0; i < 32; i++) if (model_pend[i]) e.pending[i] = 1'b1;
    if (!rst_n) begin
      e.rdata_a = '0; e.rdata_b = '0; e.busy_a = 0; e.busy_b = 0; e.pending = '0;
    end else begin
      if (ra == 0)                 e.rdata_a = '0;
      else if (w && wi == ra)      e.rdata_a = wd;
      else                         e.rdata_a = model_regs[ra];
      if (rb == 0)                 e.rdata_b = '0;
      else if (w && wi == rb)      e.rdata_b = wd;
      else                         e.rdata_b = model_regs[rb];
      e.busy_a = (ra != 0) && model_pend[ra] && !(w && wi == ra);
      e.busy_b = (rb != 0) && model_pend[rb] && !(w && wi == rb);
    end
    q.push_back(e);
    if (rst_n) begin
      if (w && wi != 0) model_regs[wi] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) model_pend[i] = 1'b0;
      end else begin
        if (w && wi != 0)  model_pend[wi] = 1'b0;
        if (ps && pi != 0) model_pend[pi] = 1'b1;
      end
    end
  endtask

  task automatic idle_inputs();
    we = 0; windex = '0; win = '0; pend_set = 0; pend_index = '0; flush = 0;
  endtask

  // Hold reset for one checked cycle (with a write presented), then release cleanly.
  task automatic reset_cycle();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    drive(1, 5, 32'hFFFF_FFFF, 5, 5, 1, 5, 0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rdata_a", rdata_a, e.rdata_a);
      chk("rdata_b", rdata_b, e.rdata_b);
      chk("busy_a", {31'd0, busy_a}, {31'd0, e.busy_a});
      chk("busy_b", {31'd0, busy_b}, {31'd0, e.busy_b});
      chk("pending", pending, e.pending);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    drive(0, 0, 0, 5, 0, 0, 0, 0);
    // reset mid-run after r5 written
    drive(1, 5, 32'h0000_1234, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 5, 5, 1, 6, 0);
    reset_cycle();
    drive(0, 0, 0, 5, 6, 0, 0, 0);
    // write with bypass, then steady-state read
    drive(1, 7, 32'hDEAD_BEEF, 7, 1, 0, 0, 0);
    drive(0, 0, 0, 7, 7, 0, 0, 0);
    // r0 stays zero
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on r9
    drive(0, 0, 0, 0, 0, 1, 9, 0);
    drive(0, 0, 0, 9, 9, 0, 0, 0);
    drive(1, 9, 32'h0000_0042, 9, 2, 0, 0, 0);
    drive(0, 0, 0, 9, 0, 0, 0, 0);
    // set/write collision on r3
    drive(1, 3, 32'hCAFE_0003, 3, 0, 1, 3, 0);
    drive(0, 0, 0, 3, 3, 0, 0, 0);
    // flush beats a simultaneous set
    drive(0, 0, 0, 0, 0, 1, 4, 0);
    drive(0, 0, 0, 4, 0, 1, 12, 0);
    drive(0, 0, 0, 4, 12, 1, 20, 1);
    drive(0, 0, 0, 4, 20, 0, 0, 0);
    // pend_set at r0 is ignored
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 3, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      bit  narrow;
      int  hi;
      narrow = ($urandom_range(0, 3) != 0);
      hi = narrow ? 7 : 31;
      drive($urandom_range(0, 1), $urandom_range(0, hi), $urandom,
            $urandom_range(0, hi), $urandom_range(0, hi),
            ($urandom_range(0, 2) == 0), $urandom_range(0, hi),
            ($urandom_range(0, 19) == 0));
      if (n == 1500) reset_cycle();
    end

    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #4;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
